// File: rtl/dmem_arb_pkg.sv
// Shared state encodings and default sizing for the two-requester
// data-memory arbiter.
package dmem_arb_pkg;

  localparam int DMEM_DATA_WIDTH = 16;
  localparam int DMEM_ADX_LENGTH = 11;
  localparam int DMEM_BURST_MAX  = 4;
  localparam int BCNT_W          = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SERVE0 = 2'b01,
    SERVE1 = 2'b10
  } arb_state_e;

endpackage

// File: rtl/dmem_arb_rr.sv
// Two-way round-robin pick: a tie goes to whichever requester was not served
// last (last: 0 = r0, 1 = r1). pick: 0 selects r0, 1 selects r1.
module dmem_arb_rr (
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic pick
);

  assign pick = (req0 & req1) ? ~last : req1;

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates two requesters onto one single-port data memory: round-robin on
// ties, optional locked bursts capped at BURST_MAX, registered grant and rdata.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int DATA_WIDTH = DMEM_DATA_WIDTH,
  parameter int ADX_LENGTH = DMEM_ADX_LENGTH,
  parameter int BURST_MAX  = DMEM_BURST_MAX
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  r0_req,
  input  logic                  r0_we,
  input  logic                  r0_lock,
  input  logic [ADX_LENGTH-1:0] r0_adx,
  input  logic [DATA_WIDTH-1:0] r0_wdata,
  output logic                  r0_gnt,
  output logic                  r0_rvalid,
  output logic [DATA_WIDTH-1:0] r0_rdata,
  input  logic                  r1_req,
  input  logic                  r1_we,
  input  logic                  r1_lock,
  input  logic [ADX_LENGTH-1:0] r1_adx,
  input  logic [DATA_WIDTH-1:0] r1_wdata,
  output logic                  r1_gnt,
  output logic                  r1_rvalid,
  output logic [DATA_WIDTH-1:0] r1_rdata,
  output logic [ADX_LENGTH-1:0] mem_adx,
  output logic                  mem_WrEn,
  inout  wire  [DATA_WIDTH-1:0] mem_data
);

  arb_state_e            state, state_nxt;
  logic [BCNT_W-1:0]     bcnt, bcnt_nxt;
  logic                  last, last_nxt;
  logic                  pick;
  logic [ADX_LENGTH-1:0] adx_q;
  logic                  acc0, acc1, acc, sel_we, burst_end;
  logic [ADX_LENGTH-1:0] sel_adx;
  logic [DATA_WIDTH-1:0] sel_wdata;

  assign acc0      = (state == SERVE0) & r0_req;
  assign acc1      = (state == SERVE1) & r1_req;
  assign acc       = acc0 | acc1;
  assign sel_we    = acc1 ? r1_we    : r0_we;
  assign sel_adx   = acc1 ? r1_adx   : r0_adx;
  assign sel_wdata = acc1 ? r1_wdata : r0_wdata;
  // bcnt counts accesses already done in this grant; the current one is the last
  assign burst_end = (bcnt == BCNT_W'(BURST_MAX - 1));

  assign r0_gnt = (state == SERVE0);
  assign r1_gnt = (state == SERVE1);

  // Reset overrides the write strobe so a burst cut by reset cannot corrupt memory
  assign mem_adx  = acc ? sel_adx : adx_q;
  assign mem_WrEn = rst | ~(acc & sel_we);
  assign mem_data = (!rst && acc && sel_we) ? sel_wdata : 'z;

  dmem_arb_rr u_rr (
    .req0 (r0_req),
    .req1 (r1_req),
    .last (last),
    .pick (pick)
  );

  always_comb begin
    state_nxt = state;
    bcnt_nxt  = bcnt;
    last_nxt  = last;
    case (state)
      IDLE: begin
        if (r0_req | r1_req) begin
          state_nxt = pick ? SERVE1 : SERVE0;
          last_nxt  = pick;
          bcnt_nxt  = '0;
        end
      end
      SERVE0: begin
        if (!r0_req || !r0_lock || burst_end) begin
          bcnt_nxt = '0;
          if (r1_req) begin
            state_nxt = SERVE1;
            last_nxt  = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          bcnt_nxt = bcnt + 1'b1;
        end
      end
      SERVE1: begin
        if (!r1_req || !r1_lock || burst_end) begin
          bcnt_nxt = '0;
          if (r0_req) begin
            state_nxt = SERVE0;
            last_nxt  = 1'b0;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          bcnt_nxt = bcnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      bcnt      <= '0;
      last      <= 1'b1;
      adx_q     <= '0;
      r0_rvalid <= 1'b0;
      r1_rvalid <= 1'b0;
      r0_rdata  <= '0;
      r1_rdata  <= '0;
    end else begin
      state     <= state_nxt;
      bcnt      <= bcnt_nxt;
      last      <= last_nxt;
      if (acc) adx_q <= sel_adx;
      r0_rvalid <= acc0 & ~r0_we;
      r1_rvalid <= acc1 & ~r1_we;
      if (acc0 & ~r0_we) r0_rdata <= mem_data;
      if (acc1 & ~r1_we) r1_rdata <= mem_data;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: attached memory model, transaction-level reference
// model (owner / burst count / round-robin), directed scenarios and random traffic.
module tb_dmem_arbiter;
  localparam int DW    = 16;
  localparam int AW    = 11;
  localparam int BM    = 4;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          preload = 1'b1;
  logic          req [2];
  logic          we  [2];
  logic          lock[2];
  logic [AW-1:0] adx  [2];
  logic [DW-1:0] wdata[2];
  logic          gnt0, gnt1, rv0, rv1, mem_WrEn;
  logic [DW-1:0] rd0, rd1;
  logic [AW-1:0] mem_adx;
  tri0  [DW-1:0] mem_data;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.DATA_WIDTH(DW), .ADX_LENGTH(AW), .BURST_MAX(BM)) dut (
    .clk(clk), .rst(rst),
    .r0_req(req[0]), .r0_we(we[0]), .r0_lock(lock[0]), .r0_adx(adx[0]), .r0_wdata(wdata[0]),
    .r0_gnt(gnt0), .r0_rvalid(rv0), .r0_rdata(rd0),
    .r1_req(req[1]), .r1_we(we[1]), .r1_lock(lock[1]), .r1_adx(adx[1]), .r1_wdata(wdata[1]),
    .r1_gnt(gnt1), .r1_rvalid(rv1), .r1_rdata(rd1),
    .mem_adx(mem_adx), .mem_WrEn(mem_WrEn), .mem_data(mem_data)
  );

  function automatic logic [DW-1:0] init_word(input int a);
    return DW'(a * 40503) ^ 16'h5A3C;
  endfunction

  // Attached memory: write on low WrEn, drives the bus only for a predicted read
  logic [DW-1:0] phys[DEPTH];
  logic          mem_oe;
  assign mem_data = mem_oe ? phys[mem_adx] : 'z;
  always @(posedge clk) begin
    if (preload) for (int i = 0; i < DEPTH; i++) phys[i] <= init_word(i);
    else if (!mem_WrEn) phys[mem_adx] <= mem_data;
  end

  // Reference model: who owns the memory, how many accesses it has had, who went last
  int            own = -1;
  int            cnt = 0;
  int            lst = 1;
  logic [DW-1:0] ref_mem[DEPTH];
  logic          exp_rv[2];
  logic [DW-1:0] exp_rd[2];
  logic [AW-1:0] exp_adx;
  logic          m_acc, m_wr, m_rd, m_done;
  int            m_pick;
  logic [AW-1:0] m_adx;

  always_comb begin
    m_acc  = 1'b0;
    m_wr   = 1'b0;
    m_rd   = 1'b0;
    m_done = 1'b0;
    m_adx  = exp_adx;
    m_pick = 0;
    if (req[0] && req[1]) m_pick = 1 - lst;
    else if (req[1])      m_pick = 1;
    if (own >= 0) begin
      m_acc  = req[own];
      m_wr   = req[own] && we[own];
      m_rd   = req[own] && !we[own];
      if (req[own]) m_adx = adx[own];
      m_done = !req[own] || !lock[own] || (cnt == BM - 1);
    end
  end
  assign mem_oe = m_rd && !rst;

  always @(posedge clk) begin
    if (preload) for (int i = 0; i < DEPTH; i++) ref_mem[i] <= init_word(i);
    else if (!rst && m_wr) ref_mem[m_adx] <= wdata[own];
    if (rst) begin
      own <= -1; cnt <= 0; lst <= 1;
      exp_rv[0] <= 1'b0; exp_rv[1] <= 1'b0;
      exp_rd[0] <= '0;   exp_rd[1] <= '0;
      exp_adx <= '0;
    end else begin
      exp_rv[0] <= m_rd && (own == 0);
      exp_rv[1] <= m_rd && (own == 1);
      if (m_rd)  exp_rd[own] <= ref_mem[m_adx];
      if (m_acc) exp_adx <= m_adx;
      if (own < 0) begin
        if (req[0] || req[1]) begin own <= m_pick; lst <= m_pick; cnt <= 0; end
      end else if (m_done) begin
        cnt <= 0;
        if (req[1 - own]) begin own <= 1 - own; lst <= 1 - own; end
        else own <= -1;
      end else begin
        cnt <= cnt + 1;
      end
    end
  end

  task automatic clear_inputs();
    for (int n = 0; n < 2; n++) begin
      req[n] = 1'b0; we[n] = 1'b0; lock[n] = 1'b0; adx[n] = '0; wdata[n] = '0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1; clear_inputs();
    @(negedge clk); @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk); rst = 1'b1; #1;
    n_cmp++; if ({gnt0, gnt1, rv0, rv1} !== 4'b0000) begin
      n_bad++; $display("FAIL reset.flags got %b want 0000", {gnt0, gnt1, rv0, rv1}); end
    n_cmp++; if ({rd0, rd1} !== 32'h0) begin
      n_bad++; $display("FAIL reset.rdata got %h %h want 0 0", rd0, rd1); end
    n_cmp++; if (mem_adx !== 11'h000 || mem_WrEn !== 1'b1) begin
      n_bad++; $display("FAIL reset.mem got adx=%h wren=%b want 000 1", mem_adx, mem_WrEn); end
    rst = 1'b0;
  endtask

  task automatic test_idle();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      we[0] = 1'b1; we[1] = 1'b1;
      wdata[0] = DW'($urandom_range(1, 16'hFFFF)); wdata[1] = DW'($urandom_range(1, 16'hFFFF));
      adx[0] = AW'($urandom); adx[1] = AW'($urandom);
      #1;
      n_cmp++; if (mem_WrEn !== 1'b1 || mem_data !== 16'h0) begin
        n_bad++; $display("FAIL idle.bus got wren=%b data=%h want 1 undriven", mem_WrEn, mem_data); end
      n_cmp++; if ({gnt0, gnt1} !== 2'b00 || mem_adx !== 11'h000) begin
        n_bad++; $display("FAIL idle.state got gnt=%b adx=%h want 00 000", {gnt0, gnt1}, mem_adx); end
    end
    clear_inputs();
  endtask

  task automatic test_write_read();
    @(negedge clk);
    req[0] = 1'b1; we[0] = 1'b1; lock[0] = 1'b0; adx[0] = 11'h010; wdata[0] = 16'hBEEF;
    #1;
    n_cmp++; if (gnt0 !== 1'b0 || mem_WrEn !== 1'b1) begin
      n_bad++; $display("FAIL wr.pre got gnt=%b wren=%b want 0 1", gnt0, mem_WrEn); end
    @(negedge clk); #1;
    n_cmp++; if (gnt0 !== 1'b1 || mem_WrEn !== 1'b0) begin
      n_bad++; $display("FAIL wr.access got gnt=%b wren=%b want 1 0", gnt0, mem_WrEn); end
    n_cmp++; if (mem_adx !== 11'h010 || mem_data !== 16'hBEEF) begin
      n_bad++; $display("FAIL wr.bus got adx=%h data=%h want 010 beef", mem_adx, mem_data); end
    @(negedge clk); we[0] = 1'b0; #1;
    n_cmp++; if (gnt0 !== 1'b0 || mem_WrEn !== 1'b1 || mem_adx !== 11'h010) begin
      n_bad++; $display("FAIL wr.release got gnt=%b wren=%b adx=%h want 0 1 010", gnt0, mem_WrEn, mem_adx); end
    @(negedge clk); #1;
    n_cmp++; if (gnt0 !== 1'b1 || mem_WrEn !== 1'b1 || rv0 !== 1'b0) begin
      n_bad++; $display("FAIL rd.access got gnt=%b wren=%b rv=%b want 1 1 0", gnt0, mem_WrEn, rv0); end
    @(negedge clk); req[0] = 1'b0; #1;
    n_cmp++; if (rv0 !== 1'b1 || rd0 !== 16'hBEEF) begin
      n_bad++; $display("FAIL rd.data got rv=%b rdata=%h want 1 beef", rv0, rd0); end
    @(negedge clk); #1;
    n_cmp++; if (rv0 !== 1'b0 || rd0 !== 16'hBEEF) begin
      n_bad++; $display("FAIL rd.pulse got rv=%b rdata=%h want 0 beef", rv0, rd0); end
    clear_inputs();
  endtask

  task automatic test_tie();
    logic [AW-1:0] a0, a1;
    logic [DW-1:0] w0, w1;
    do_reset();
    a0 = AW'($urandom_range(11'h200, 11'h2FF)); a1 = AW'($urandom_range(11'h300, 11'h3FF));
    w0 = ref_mem[a0]; w1 = ref_mem[a1];
    @(negedge clk);
    req[0] = 1'b1; req[1] = 1'b1; adx[0] = a0; adx[1] = a1;
    @(negedge clk); #1;
    n_cmp++; if ({gnt0, gnt1} !== 2'b10 || mem_adx !== a0) begin
      n_bad++; $display("FAIL tie.first got gnt=%b adx=%h want 10 %h", {gnt0, gnt1}, mem_adx, a0); end
    @(negedge clk); req[0] = 1'b0; #1;
    n_cmp++; if ({gnt0, gnt1} !== 2'b01 || rv0 !== 1'b1 || rd0 !== w0) begin
      n_bad++; $display("FAIL tie.second got gnt=%b rv0=%b rd0=%h want 01 1 %h", {gnt0, gnt1}, rv0, rd0, w0); end
    @(negedge clk); req[1] = 1'b0; #1;
    n_cmp++; if ({gnt0, gnt1} !== 2'b00 || rv1 !== 1'b1 || rd1 !== w1) begin
      n_bad++; $display("FAIL tie.done got gnt=%b rv1=%b rd1=%h want 00 1 %h", {gnt0, gnt1}, rv1, rd1, w1); end
    clear_inputs();
  endtask

  task automatic test_lock_burst();
    int held;
    @(negedge clk);
    req[1] = 1'b1; lock[1] = 1'b1; we[1] = 1'b1;
    adx[1] = AW'($urandom_range(11'h100, 11'h1FF)); wdata[1] = DW'($urandom);
    @(negedge clk);
    req[0] = 1'b1; we[0] = 1'b0; adx[0] = 11'h010;
    #1;
    held = 0;
    while (gnt1 && !mem_WrEn && held < 8) begin
      held++;
      @(negedge clk);
      adx[1] = AW'($urandom_range(11'h100, 11'h1FF)); wdata[1] = DW'($urandom);
      #1;
    end
    n_cmp++; if (held !== BM) begin
      n_bad++; $display("FAIL lock.count got %0d accesses want %0d", held, BM); end
    n_cmp++; if ({gnt0, gnt1} !== 2'b10) begin
      n_bad++; $display("FAIL lock.handoff got gnt=%b want 10", {gnt0, gnt1}); end
    req[1] = 1'b0;
    @(negedge clk); clear_inputs(); #1;
    n_cmp++; if (rv0 !== 1'b1 || rd0 !== 16'hBEEF) begin
      n_bad++; $display("FAIL lock.r0read got rv=%b rdata=%h want 1 beef", rv0, rd0); end
  endtask

  task automatic test_no_cross();
    logic [DW-1:0] w1;
    w1 = ref_mem[11'h030];
    @(negedge clk); req[1] = 1'b1; adx[1] = 11'h030;
    @(negedge clk);
    @(negedge clk); req[1] = 1'b0; #1;
    n_cmp++; if (rv1 !== 1'b1 || rd1 !== w1) begin
      n_bad++; $display("FAIL cross.load got rv1=%b rd1=%h want 1 %h", rv1, rd1, w1); end
    req[0] = 1'b1; adx[0] = 11'h010;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); #1;
      n_cmp++; if (rv1 !== 1'b0 || rd1 !== w1 || gnt1 !== 1'b0) begin
        n_bad++; $display("FAIL cross.hold got rv1=%b rd1=%h gnt1=%b want 0 %h 0", rv1, rd1, gnt1, w1); end
    end
    n_cmp++; if (rd0 !== 16'hBEEF) begin
      n_bad++; $display("FAIL cross.r0 got rd0=%h want beef", rd0); end
    clear_inputs();
  endtask

  task automatic test_reset_midburst();
    logic [DW-1:0] pre;
    pre = ref_mem[11'h020];
    @(negedge clk);
    req[0] = 1'b1; we[0] = 1'b1; lock[0] = 1'b1; adx[0] = 11'h021; wdata[0] = DW'($urandom);
    @(negedge clk); #1;
    n_cmp++; if (gnt0 !== 1'b1) begin
      n_bad++; $display("FAIL rstmid.gnt got %b want 1", gnt0); end
    @(negedge clk);
    adx[0] = 11'h020; wdata[0] = ~pre; rst = 1'b1; #1;
    n_cmp++; if (mem_WrEn !== 1'b1 || mem_data !== 16'h0) begin
      n_bad++; $display("FAIL rstmid.wren got wren=%b data=%h want 1 undriven", mem_WrEn, mem_data); end
    @(negedge clk); rst = 1'b0; clear_inputs(); #1;
    n_cmp++; if ({gnt0, gnt1, rv0, rv1} !== 4'b0000 || {rd0, rd1} !== 32'h0 || mem_adx !== 11'h000) begin
      n_bad++; $display("FAIL rstmid.outs got flags=%b rd=%h %h adx=%h want 0000 0 0 000",
                        {gnt0, gnt1, rv0, rv1}, rd0, rd1, mem_adx); end
    n_cmp++; if (phys[11'h020] !== pre) begin
      n_bad++; $display("FAIL rstmid.mem got %h want %h", phys[11'h020], pre); end
  endtask

  task automatic test_random();
    int wt0, wt1;
    logic xg0, xg1, xw;
    wt0 = 0; wt1 = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      for (int n = 0; n < 2; n++) begin
        req[n]   = ($urandom_range(0, 9) < 7);
        we[n]    = $urandom_range(0, 1) == 1;
        lock[n]  = ($urandom_range(0, 9) < 6);
        adx[n]   = AW'($urandom_range(11'h040, 11'h05F));
        wdata[n] = DW'($urandom);
      end
      #1;
      xg0 = (own == 0); xg1 = (own == 1); xw = !m_wr;
      n_cmp++; if ({gnt0, gnt1} !== {xg0, xg1}) begin
        n_bad++; $display("FAIL rnd.gnt c=%0d got %b want %b", c, {gnt0, gnt1}, {xg0, xg1}); end
      n_cmp++; if ({rv0, rv1} !== {exp_rv[0], exp_rv[1]} || rd0 !== exp_rd[0] || rd1 !== exp_rd[1]) begin
        n_bad++; $display("FAIL rnd.rd c=%0d got %b %h %h want %b %h %h", c, {rv0, rv1}, rd0, rd1,
                          {exp_rv[0], exp_rv[1]}, exp_rd[0], exp_rd[1]); end
      n_cmp++; if (mem_WrEn !== xw || mem_adx !== m_adx) begin
        n_bad++; $display("FAIL rnd.mem c=%0d got wren=%b adx=%h want %b %h", c, mem_WrEn, mem_adx, xw, m_adx); end
      if (m_wr) begin
        n_cmp++; if (mem_data !== wdata[own]) begin
          n_bad++; $display("FAIL rnd.wdata c=%0d got %h want %h", c, mem_data, wdata[own]); end
      end else if (!m_acc) begin
        n_cmp++; if (mem_data !== 16'h0) begin
          n_bad++; $display("FAIL rnd.float c=%0d got %h want undriven", c, mem_data); end
      end
      wt0 = (req[0] && !gnt0) ? wt0 + 1 : 0;
      wt1 = (req[1] && !gnt1) ? wt1 + 1 : 0;
      n_cmp++; if (wt0 > BM + 1 || wt1 > BM + 1) begin
        n_bad++; $display("FAIL rnd.wait c=%0d got %0d %0d cycles want <= %0d", c, wt0, wt1, BM + 1); end
    end
    @(negedge clk); clear_inputs();
  endtask

  initial begin
    clear_inputs();
    @(negedge clk); preload = 1'b0;
    test_reset();
    test_idle();
    test_write_read();
    test_tie();
    test_lock_burst();
    test_no_cross();
    test_reset_midburst();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; it SHALL name them clk and rst.
REQ-002 The block SHALL provide parameter DATA_WIDTH, default 16, the memory word width.
REQ-003 The block SHALL provide parameter ADX_LENGTH, default 11, the memory address width.
REQ-004 The block SHALL provide parameter BURST_MAX, default 4, the maximum accesses per locked grant.
REQ-005 clk  input  1  rising-edge clock for the arbiter and the attached data memory.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 rN_req  input  1  requester N (N=0,1) wants an access this cycle.
REQ-008 rN_we  input  1  1 = write, 0 = read, for requester N.
REQ-009 rN_lock  input  1  requester N asks to keep the grant after the current access.
REQ-010 rN_adx  input  ADX_LENGTH  access address for requester N.
REQ-011 rN_wdata  input  DATA_WIDTH  write data for requester N.
REQ-012 rN_gnt  output  1  registered grant to requester N.
REQ-013 rN_rvalid  output  1  one-cycle pulse marking valid rN_rdata.
REQ-014 rN_rdata  output  DATA_WIDTH  registered read data for requester N.
REQ-015 mem_adx  output  ADX_LENGTH  drives the memory address.
REQ-016 mem_WrEn  output  1  active-low memory write enable.
REQ-017 mem_data  inout  DATA_WIDTH  memory data bus; driven only on writes, high-Z otherwise.

Function
REQ-018 The FSM SHALL have exactly three states: IDLE, SERVE0 and SERVE1; rN_gnt SHALL be 1 only in SERVEN.
REQ-019 An access SHALL occur on every cycle in which SERVEN is active and rN_req=1.
REQ-020 During that access, mem_adx SHALL equal rN_adx, mem_WrEn SHALL equal ~rN_we, and mem_data SHALL be driven with rN_wdata only when rN_we=1.
REQ-021 When no access is occurring, mem_WrEn SHALL be 1, mem_data SHALL be Z and mem_adx SHALL hold its last value.
REQ-022 On a read access, rN_rdata SHALL capture mem_data at that rising edge, and rN_rvalid SHALL be 1 for exactly the following cycle (latency 1).
REQ-023 Write accesses SHALL NOT assert rN_rvalid; rdata of the non-served requester SHALL hold.
REQ-024 From IDLE, a single requester SHALL be granted on the next cycle.
REQ-025 When both requesters request, the requester not served last SHALL win (round-robin); after reset, r0 SHALL win the first tie.
REQ-026 The grant SHALL be released after an access with rN_lock=0, when rN_req=0 in SERVEN, or after BURST_MAX accesses in one grant.
REQ-027 A 3-bit burst counter SHALL clear on each new grant; wrap-around is impossible because the grant is released at BURST_MAX.
REQ-028 On release, if the other requester has req=1, the FSM SHALL go directly to its SERVE state; otherwise it SHALL go to IDLE.
REQ-029 No requester SHALL wait more than BURST_MAX+1 cycles while the other holds the grant.

Reset
REQ-030 While rst=1, mem_WrEn SHALL be forced to 1 combinationally, so that no write occurs in the reset cycle, including a reset asserted mid-burst.
REQ-031 After reset, the state SHALL be IDLE, both gnt and rvalid SHALL be 0, both rdata SHALL be 0, mem_adx SHALL be 0, mem_data SHALL be Z, the burst count SHALL be 0 and last-served SHALL be r1.
REQ-032 The arbiter SHALL NOT alter memory contents on reset; the memory's own preload is independent.

Structure
REQ-033 State encodings and the default width and BURST_MAX localparams SHALL live in the shared package/header dmem_arb_pkg.
REQ-034 The tie-break logic SHALL be one sub-module, dmem_arb_rr (inputs: req0, req1, last; output: pick); everything else SHALL be flat.

Verification
REQ-035 The bench SHALL cover this case: r0 writes 16'hBEEF to 11'h010 unlocked, then reads it back -> gnt the cycle after req, mem_WrEn=0 for one cycle, read rvalid one cycle after the read access, rdata=16'hBEEF.
REQ-036 The bench SHALL cover this case: r0 and r1 request from reset simultaneously, unlocked -> r0 is served first, then r1 the next cycle, with no IDLE gap.
REQ-037 The bench SHALL cover this case: r1 is locked with req held and r0 requests -> r1 gets exactly 4 accesses, then r0 is granted.
REQ-038 The bench SHALL cover this case: rst is asserted during an r0 locked write to 11'h020 -> mem_WrEn=1 in that cycle, 11'h020 is unchanged, and all outputs are at reset values next cycle.
REQ-039 The bench SHALL cover this case: with no requests -> mem_data stays Z, mem_WrEn=1 and the state stays IDLE.
REQ-040 The bench SHALL cover this case: r0 reads 11'h010 while r1 is not granted -> r1_rvalid stays 0 and r1_rdata is unchanged.
